div4_seq: RTL and testbench

- Sequential restoring divider; the inverse of the ALU's sequential shift-add multiplier.
- Divides a 2N-bit unsigned dividend by an N-bit unsigned divisor, producing a 2N-bit quotient and an N-bit remainder.
- Uses the same init/done handshake as the multiplier, so it can sit beside it in the ALU as a future DIV opcode.
- Computes one quotient bit per clock.

---
 rtl/div4_seq.sv | 139 +++++++++++++
 tb/tb_div4_seq.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/div4_seq.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit per clock.
// Shares the init/busy/done handshake of the shift-add multiplier.
module div4_seq #(
   parameter int N = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           init,
   input  logic [2*N-1:0] A,
   input  logic [N-1:0]   B,
   output logic [2*N-1:0] Q,
   output logic [N-1:0]   R,
   output logic           busy,
   output logic           done,
   output logic           dbz
);

   localparam int CW = $clog2(2*N) + 1;
   localparam logic [CW-1:0] LAST_STEP = CW'(2*N - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [2*N-1:0] q_q, q_d;
   logic [N-1:0]   r_q, r_d;
   logic           done_q, done_d;
   logic           dbz_q, dbz_d;

   // datapath registers, not reset: always loaded on accept before use
   logic [2*N-1:0] dvd_q, dvd_d;
   logic [N-1:0]   dvs_q, dvs_d;
   logic [N:0]     rem_q, rem_d;
   logic [2*N-1:0] quo_q, quo_d;

   logic [N:0]          rem_sh;
   logic signed [N+1:0] trial;
   logic                qbit;
   logic [N:0]          rem_nx;
   logic [2*N-1:0]      quo_nx;

   // One restoring step: shift in dividend MSB, trial-subtract, keep or restore
   always_comb begin
      rem_sh = {rem_q[N-1:0], dvd_q[2*N-1]};
      trial  = $signed({1'b0, rem_sh}) - $signed({2'b00, dvs_q});
      qbit   = ~trial[N+1];
      rem_nx = qbit ? trial[N:0] : rem_sh;
      quo_nx = {quo_q[2*N-2:0], qbit};
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      q_d     = q_q;
      r_d     = r_q;
      dbz_d   = dbz_q;
      done_d  = 1'b0;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      rem_d   = rem_q;
      quo_d   = quo_q;

      case (state_q)
         S_IDLE: begin
            if (init) begin
               dvd_d = A;
               dvs_d = B;
               rem_d = '0;
               quo_d = '0;
               cnt_d = '0;
               if (B != '0) begin
                  state_d = S_RUN;
               end else begin
                  state_d = S_DONE;
                  q_d     = '1;
                  r_d     = '0;
                  dbz_d   = 1'b1;
                  done_d  = 1'b1;
               end
            end
         end
         S_RUN: begin
            dvd_d = {dvd_q[2*N-2:0], 1'b0};
            rem_d = rem_nx;
            quo_d = quo_nx;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST_STEP) begin
               state_d = S_DONE;
               q_d     = quo_nx;
               r_d     = rem_nx[N-1:0];
               dbz_d   = 1'b0;
               done_d  = 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         q_q     <= '0;
         r_q     <= '0;
         done_q  <= 1'b0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         q_q     <= q_d;
         r_q     <= r_d;
         done_q  <= done_d;
         dbz_q   <= dbz_d;
      end
   end

   always_ff @(posedge clk) begin
      dvd_q <= dvd_d;
      dvs_q <= dvs_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
   end

   assign Q    = q_q;
   assign R    = r_q;
   assign done = done_q;
   assign dbz  = dbz_q;
   assign busy = (state_q == S_RUN);

endmodule

// File: tb/tb_div4_seq.sv
// Directed bench for div4_seq: scoreboard of expected quotient/remainder/dbz,
// popped and compared when done pulses, plus latency and handshake checks.
module tb_div4_seq;

   localparam int N = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic           init;
   logic [2*N-1:0] A;
   logic [N-1:0]   B;
   logic [2*N-1:0] Q;
   logic [N-1:0]   R;
   logic           busy;
   logic           done;
   logic           dbz;

   div4_seq #(.N(N)) dut (
      .clk  (clk),
      .rst  (rst),
      .init (init),
      .A    (A),
      .B    (B),
      .Q    (Q),
      .R    (R),
      .busy (busy),
      .done (done),
      .dbz  (dbz)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] q;
      logic [3:0] r;
      logic       dbz;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic start(input logic [7:0] a, input logic [3:0] b);
      exp_t e;
      if (b == 4'd0) begin
         e.q   = 8'hFF;
         e.r   = 4'd0;
         e.dbz = 1'b1;
      end else begin
         e.q   = a / {4'b0, b};
         e.r   = 4'(a % {4'b0, b});
         e.dbz = 1'b0;
      end
      sb.push_back(e);
      A    = a;
      B    = b;
      init = 1'b1;
      @(posedge clk);
      #1;
      init = 1'b0;
   endtask

   // Waits for done, checking latency, busy coverage and the scoreboard entry.
   task automatic wait_done(input string tag, input int exp_lat);
      int   lat  = 0;
      int   bcnt = 0;
      exp_t e;
      while (done !== 1'b1 && lat < 40) begin
         if (busy === 1'b1) bcnt++;
         @(posedge clk);
         #1;
         lat++;
      end
      chk({tag, " latency"}, lat, exp_lat);
      chk({tag, " busy cycles"}, bcnt, exp_lat);
      chk({tag, " busy with done"}, {31'b0, busy}, 32'd0);
      if (sb.size() == 0) begin
         n_vec++;
         n_err++;
         $error("FAIL %s scoreboard: observed empty expected entry", tag);
      end else begin
         e = sb.pop_front();
         chk({tag, " Q"}, {24'b0, Q}, {24'b0, e.q});
         chk({tag, " R"}, {28'b0, R}, {28'b0, e.r});
         chk({tag, " dbz"}, {31'b0, dbz}, {31'b0, e.dbz});
      end
      @(posedge clk);
      #1;
      chk({tag, " done fall"}, {31'b0, done}, 32'd0);
   endtask

   initial begin
      int dcnt;
      rst  = 1'b1;
      init = 1'b0;
      A    = '0;
      B    = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset Q", {24'b0, Q}, 32'd0);
      chk("reset R", {28'b0, R}, 32'd0);
      chk("reset busy", {31'b0, busy}, 32'd0);
      chk("reset done", {31'b0, done}, 32'd0);
      chk("reset dbz", {31'b0, dbz}, 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      start(8'd100, 4'd7);
      chk("100/7 busy at accept", {31'b0, busy}, 32'd1);
      wait_done("100/7", 8);
      repeat (3) @(posedge clk);
      #1;
      chk("hold Q", {24'b0, Q}, 32'd14);
      chk("hold R", {28'b0, R}, 32'd2);

      start(8'hFF, 4'h1);  wait_done("FF/1", 8);
      start(8'hE1, 4'hF);  wait_done("E1/F", 8);
      start(8'd5, 4'd15);  wait_done("5/15", 8);
      start(8'd0, 4'd3);   wait_done("0/3", 8);

      start(8'h3C, 4'd0);
      wait_done("3C/0", 0);
      start(8'd9, 4'd2);   wait_done("9/2", 8);

      // second init mid-run must be ignored
      start(8'd100, 4'd7);
      @(posedge clk); #1;
      @(posedge clk); #1;
      A    = 8'd50;
      B    = 4'd5;
      init = 1'b1;
      @(posedge clk); #1;
      init = 1'b0;
      wait_done("ignore init", 5);

      // abort with reset mid-run
      start(8'd200, 4'd9);
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      sb.delete();
      chk("abort Q", {24'b0, Q}, 32'd0);
      chk("abort R", {28'b0, R}, 32'd0);
      chk("abort busy", {31'b0, busy}, 32'd0);
      chk("abort done", {31'b0, done}, 32'd0);
      dcnt = 0;
      repeat (15) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) dcnt++;
      end
      chk("abort no done", dcnt, 32'd0);

      start(8'd200, 4'd9); wait_done("200/9", 8);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
